bus_transfer_controller: RTL
============================

// Module: bus_transfer_controller
// PURPOSE
//   Bus master for the 4-entry register file on the shared 16-bit bus. Accepts one command
//   (MOV reg->reg, LDI imm->reg, RD reg->host) over valid/ready and sequences the register
//   file controls: register_addr, bus_register_out_en, bus_register_input_en.
//   Also drives the bus through its own tri-state enable.
//   Returns one response per command.
// PARAMETERS
//   DATA_WIDTH  16  bus / register width
//   ADDR_WIDTH  6   register address width
//   NUM_REGS    4   legal addresses are 0..NUM_REGS-1
// PORTS
//   controller_clock       in   1           single clock, all state on rising edge
//   controller_reset       in   1           asynchronous, active-low reset
//   cmd_valid              in   1           command present
//   cmd_ready              out  1           controller can accept a command
//   cmd_op                 in   2           00 MOV, 01 LDI, 10 RD, 11 reserved
//   cmd_src                in   ADDR_WIDTH  source register (MOV, RD)
//   cmd_dst                in   ADDR_WIDTH  destination register (MOV, LDI)
//   cmd_imm                in   DATA_WIDTH  immediate (LDI)
//   rsp_valid              out  1           one-cycle response strobe
//   rsp_data               out  DATA_WIDTH  moved/loaded/read value; 0 on error
//   rsp_error              out  1           qualifies rsp_valid: illegal op or address
//   register_addr          out  ADDR_WIDTH  address to register file
//   bus_register_out_en    out  1           register file drives bus
//   bus_register_input_en  out  1           register file captures bus
//   bus_drive_en           out  1           controller tri-state enable onto bus
//   bus_write_data         out  DATA_WIDTH  data into controller tri-state buffer
//   bus_read_data          in   DATA_WIDTH  resolved bus value
// BEHAVIOUR
//   - States: IDLE, READ, WRITE, RESP.
//   - Outputs decode from the state register and the latched command only, never from cmd_* inputs.
//   - Reset (controller_reset=0): state=IDLE; cmd latches, data_q, rsp_* and all bus controls are 0.
//     register_addr=0.
//   - cmd_ready = (state==IDLE) while reset is deasserted; it is 0 during reset.
//   - Accept on a rising edge with cmd_valid&cmd_ready: latch op/src/dst/imm.
//   - cmd_valid held during a busy period is ignored until the next IDLE cycle.
//   - Legality check at accept:
//     - Illegal if op=11, or a used address is >= NUM_REGS.
//     - Illegal -> RESP with rsp_error=1 and rsp_data=0. No bus control asserted.
//   - Sequences, cycles counted after the accept edge:
//     - MOV: READ -> WRITE -> RESP, rsp_valid in cycle 3.
//     - LDI: data_q<=imm, then WRITE -> RESP, rsp_valid in cycle 2.
//     - RD:  READ -> RESP, rsp_valid in cycle 2.
//   - READ cycle: register_addr=src, bus_register_out_en=1.
//     data_q<=bus_read_data at the closing edge.
//   - WRITE cycle: register_addr=dst, bus_drive_en=1, bus_write_data=data_q, bus_register_input_en=1.
//     The register file commits at the closing edge.
//   - RESP cycle:
//     - rsp_valid=1 for exactly one cycle, rsp_data=data_q.
//     - No bus control is asserted. Next state is IDLE.
//   - Invariant: bus_register_out_en & bus_drive_en is never 1 (no bus contention).
//     Each is high for at most one cycle per command.
//   - Outside READ/WRITE: register_addr holds its last value.
//     bus_register_out_en = bus_register_input_en = bus_drive_en = 0.
//   - MOV with src==dst is legal: read then rewrite the same value.
//   - Reset asserted mid-command: aborts immediately (async).
//     No further input_en and no rsp_valid.
//     A write already committed stays; an aborted WRITE cycle does not commit.
// TESTING
//   1. Reset, then RD src=2 -> out_en=1 with addr=2 in cycle 1; rsp_valid, rsp_data=0x0002,
//      rsp_error=0 in cycle 2.
//   2. LDI dst=1 imm=0xBEEF -> one cycle of input_en=1, drive_en=1, addr=1, bus_write_data=0xBEEF.
//      Following RD src=1 returns 0xBEEF.
//   3. MOV src=3 dst=0 -> out_en cycle with addr=3, then input_en cycle with addr=0 and data 0x0003.
//      rsp_data=0x0003. RD src=0 returns 0x0003.
//   4. RD src=5 and op=11 -> rsp_error=1, rsp_data=0 two cycles after accept.
//      out_en, input_en and drive_en stay 0 throughout.
//   5. Reset dropped during the WRITE cycle of LDI dst=2 imm=0x1234 -> input_en falls with reset.
//      No rsp_valid. RD src=2 after reset returns 0x0002.
//   6. cmd_valid held high over 3 random MOVs -> cmd_ready high only in IDLE.
//      Exactly 3 rsp_valid pulses. Assertion: never out_en & drive_en.

Source files
------------

// File: rtl/bus_transfer_controller.sv
// Bus master for a small register file on a shared tri-state bus.
// Runs one MOV/LDI/RD command at a time and returns one response per command.
module bus_transfer_controller #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_REGS   = 4
) (
  input  logic                  controller_clock,
  input  logic                  controller_reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_src,
  input  logic [ADDR_WIDTH-1:0] cmd_dst,
  input  logic [DATA_WIDTH-1:0] cmd_imm,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH-1:0] register_addr,
  output logic                  bus_register_out_en,
  output logic                  bus_register_input_en,
  output logic                  bus_drive_en,
  output logic [DATA_WIDTH-1:0] bus_write_data,
  input  logic [DATA_WIDTH-1:0] bus_read_data
);

  // state | meaning
  // IDLE  | waiting for a command, cmd_ready high
  // READ  | source register drives bus, data_q captures it (idle filler when err_q)
  // WRITE | controller drives data_q, destination register captures it
  // RESP  | one-cycle response strobe
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;

  localparam logic [ADDR_WIDTH-1:0] REG_LIMIT = ADDR_WIDTH'(NUM_REGS);

  logic [1:0]            state_q;
  logic [1:0]            op_q;
  logic [ADDR_WIDTH-1:0] src_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [ADDR_WIDTH-1:0] addr_hold_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_q;

  logic src_ok;
  logic dst_ok;
  logic cmd_illegal;
  logic rd_act;
  logic wr_act;
  logic resp_act;

  assign src_ok = (cmd_src < REG_LIMIT);
  assign dst_ok = (cmd_dst < REG_LIMIT);

  always_comb begin
    cmd_illegal = 1'b0;
    case (cmd_op)
      OP_MOV:  cmd_illegal = !(src_ok && dst_ok);
      OP_LDI:  cmd_illegal = !dst_ok;
      OP_RD:   cmd_illegal = !src_ok;
      default: cmd_illegal = 1'b1;
    endcase
  end

  // An illegal command still passes through READ so its error response
  // lands two cycles after accept, but with every bus control masked off.
  assign rd_act   = (state_q == ST_READ)  && !err_q;
  assign wr_act   = (state_q == ST_WRITE) && !err_q;
  assign resp_act = (state_q == ST_RESP);

  always_comb begin
    register_addr = addr_hold_q;
    if (rd_act)      register_addr = src_q;
    else if (wr_act) register_addr = dst_q;
  end

  assign cmd_ready             = (state_q == ST_IDLE) && controller_reset;
  assign bus_register_out_en   = rd_act;
  assign bus_register_input_en = wr_act;
  assign bus_drive_en          = wr_act;
  assign bus_write_data        = wr_act ? data_q : '0;
  assign rsp_valid             = resp_act;
  assign rsp_error             = resp_act && err_q;
  assign rsp_data              = (resp_act && !err_q) ? data_q : '0;

  always_ff @(posedge controller_clock or negedge controller_reset) begin
    if (!controller_reset) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      addr_hold_q <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      addr_hold_q <= register_addr;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            src_q <= cmd_src;
            dst_q <= cmd_dst;
            err_q <= cmd_illegal;
            if (cmd_illegal) begin
              state_q <= ST_READ;
            end else if (cmd_op == OP_LDI) begin
              data_q  <= cmd_imm;
              state_q <= ST_WRITE;
            end else begin
              state_q <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (!err_q) data_q <= bus_read_data;
          state_q <= (op_q == OP_MOV && !err_q) ? ST_WRITE : ST_RESP;
        end
        ST_WRITE: state_q <= ST_RESP;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
